// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory burst read path.
// Burst size encodings, controller states and the word-count helper.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      COLLECT = 2'd2,
      DRAIN   = 2'd3
   } state_e;

   localparam logic [1:0] ACC_1W  = 2'b00;
   localparam logic [1:0] ACC_4W  = 2'b01;
   localparam logic [1:0] ACC_8W  = 2'b10;
   localparam logic [1:0] ACC_16W = 2'b11;

   localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;

   function automatic logic [4:0] burst_words(input logic [1:0] size);
      logic [4:0] w;
      case (size)
         ACC_1W:  w = 5'd1;
         ACC_4W:  w = 5'd4;
         ACC_8W:  w = 5'd8;
         ACC_16W: w = 5'd16;
         default: w = 5'd1;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/rd_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
// Flush wins over a same-cycle push or pop.
module rd_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign rdata   = mem_q[rd_q];
   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/mem_burst_rd_ctrl.sv
// Burst read front end: issues one memory burst at a time and buffers
// the returned words, tagging the last word of each burst.
module mem_burst_rd_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   input  logic              flush,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_acc_size,
   output logic              mem_enable,
   output logic              mem_wren,
   input  logic              mem_busy,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;

   logic [4:0]        words_q;
   logic              beat_last;
   logic [CW-1:0]     occ;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     free;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic [DATA_W:0]   head;

   assign words_q   = burst_words(size_q);
   assign beat_last = (cnt_q == words_q - 5'd1);

   // Words still owed by the memory stay reserved so a burst never overflows.
   assign outstanding = (state_q == ISSUE || state_q == COLLECT)
                      ? CW'(words_q - cnt_q) : '0;
   assign free = CW'(FIFO_DEPTH) - occ - outstanding;

   assign mem_addr     = addr_q;
   assign mem_acc_size = size_q;
   assign mem_wren     = 1'b0;

   assign rsp_valid = !fifo_empty && !flush;
   assign rsp_data  = fifo_empty ? '0 : head[DATA_W-1:0];
   assign rsp_last  = !fifo_empty && head[DATA_W];
   assign pop       = rsp_valid && rsp_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      size_d     = size_q;
      req_ready  = 1'b0;
      mem_enable = 1'b0;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = !flush && (free >= CW'(burst_words(req_size)));
            if (req_valid && req_ready) begin
               addr_d  = req_addr & ALIGN_MASK;
               size_d  = req_size;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mem_enable = 1'b1;
            cnt_d      = '0;
            state_d    = flush ? DRAIN : COLLECT;
         end
         COLLECT: begin
            if (mem_busy) begin
               cnt_d = cnt_q + 5'd1;
               push  = 1'b1;
            end
            if (mem_busy && beat_last) state_d = IDLE;
            else if (flush)            state_d = DRAIN;
         end
         DRAIN: begin
            if (mem_busy) begin
               cnt_d = cnt_q + 5'd1;
               if (beat_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
      end
   end

   rd_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .wdata ({push && beat_last, mem_rdata}),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .count (occ)
   );

endmodule
